// File: rtl/serial_link_pkg.sv
// Types, default width and parity helper shared by the serializer and deserializer.
// The parity helper zero-extends its argument, so any WIDTH up to 16 can use it.
package serial_link_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } link_state_t;

    function automatic logic even_parity(input logic [15:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// One-word valid/ready holding register with sticky overrun on dropped words.
// Latency: a loaded word is visible the cycle after load_vld.
// Backpressure: a word arriving while full and not being consumed is dropped and raises overrun.
module deser_hold_reg #(
    parameter int DAT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_vld,
    input  logic [DAT_W-1:0] load_dat,
    output logic [DAT_W-1:0] hold_dat,
    output logic             hold_vld,
    input  logic             hold_rdy,
    output logic             overrun,
    input  logic             clear_overrun
);

    logic room;
    logic drop;

    // A consume on the same edge frees the slot for the incoming word.
    assign room = !hold_vld || hold_rdy;
    assign drop = load_vld && !room;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_dat <= '0;
            hold_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load_vld && room) begin
                hold_dat <= load_dat;
                hold_vld <= 1'b1;
            end else if (hold_vld && hold_rdy) begin
                hold_vld <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Framed MSB-first serial-to-parallel capture; DESER_PARITY_EN adds a trailing even-parity bit and parity_err.
// Latency: out_valid rises the cycle after the final bit is sampled; backpressure via one-word hold, overflow sets overrun.
module serial_deserializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             bit_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clear_overrun
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef DESER_PARITY_EN
    localparam int HOLD_W = WIDTH + 1;
`else
    localparam int HOLD_W = WIDTH;
`endif

    link_state_t      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic [HOLD_W-1:0] load_dat;
    logic [HOLD_W-1:0] hold_dat;

    assign shifted = {sreg_q[WIDTH-2:0], serial_in};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;

        // A qualified frame_start always begins a fresh frame, abandoning any partial one.
        if (bit_en && frame_start) begin
            state_d = SHIFT;
            sreg_d  = {{(WIDTH-1){1'b0}}, serial_in};
            cnt_d   = CNT_W'(1);
        end else if (bit_en) begin
            case (state_q)
                SHIFT: begin
                    sreg_d = shifted;
                    if (cnt_q == LAST_CNT) begin
`ifdef DESER_PARITY_EN
                        state_d = PARITY;
                        cnt_d   = CNT_W'(WIDTH);
`else
                        state_d   = IDLE;
                        cnt_d     = '0;
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    word_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef DESER_PARITY_EN
    // Data is already complete in sreg_q; the current bit is the parity bit.
    assign load_dat = {even_parity(16'(sreg_q)) ^ serial_in, sreg_q};
`else
    assign load_dat = shifted;
`endif

    deser_hold_reg #(
        .DAT_W(HOLD_W)
    ) u_hold (
        .clock         (clock),
        .reset_n       (reset_n),
        .load_vld      (word_done),
        .load_dat      (load_dat),
        .hold_dat      (hold_dat),
        .hold_vld      (out_valid),
        .hold_rdy      (out_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    assign out_data = hold_dat[WIDTH-1:0];
    assign busy     = (state_q != IDLE);

`ifdef DESER_PARITY_EN
    assign parity_err = hold_dat[WIDTH];
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: bit-list reference model, directed plan cases, then random traffic.
module tb_serial_deserializer;

    localparam int WIDTH = 4;
`ifdef DESER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             serial_in = 1'b0;
    logic             bit_en = 1'b0;
    logic             frame_start = 1'b0;
    logic             out_ready = 1'b0;
    logic             clear_overrun = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model state: bits received so far in the open frame, hold occupancy, overrun.
    logic             frame_q[$];
    logic [WIDTH:0]   exp_q[$];
    logic             m_full = 1'b0;
    logic             m_ovr = 1'b0;

    always #5 clock = ~clock;

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .bit_en        (bit_en),
        .frame_start   (frame_start),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
`ifdef DESER_PARITY_EN
        ,
        .parity_err    (parity_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic fs);
        bit_en      = 1'b1;
        serial_in   = b;
        frame_start = fs;
        tick();
        bit_en      = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input int gap, input logic par_flip);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            drive_bit(word[i], i == WIDTH - 1);
            if (i != 0 || FRAME_BITS > WIDTH) begin
                repeat (gap) begin
                    tick();
                    chk("gap_busy", busy, 1);
                end
            end
        end
`ifdef DESER_PARITY_EN
        drive_bit((^word) ^ par_flip, 1'b0);
`endif
    endtask

    // Reference model: frames are lists of bits; completion, hold and overrun follow the word rules.
    always @(posedge clock) begin : model
        logic             done;
        logic             room;
        logic [WIDTH-1:0] w;
        logic             err;
        done = 1'b0;
        w    = '0;
        err  = 1'b0;
        if (!reset_n) begin
            frame_q.delete();
            exp_q.delete();
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (bit_en && frame_start) begin
                frame_q.delete();
                frame_q.push_back(serial_in);
            end else if (bit_en && frame_q.size() != 0) begin
                frame_q.push_back(serial_in);
                if (frame_q.size() == FRAME_BITS) begin
                    for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], frame_q[i]};
`ifdef DESER_PARITY_EN
                    for (int i = 0; i < FRAME_BITS; i++) err = err ^ frame_q[i];
`endif
                    done = 1'b1;
                    frame_q.delete();
                end
            end
            room = !m_full || out_ready;
            if (m_full && out_ready) m_full = 1'b0;
            if (done && room) begin
                m_full = 1'b1;
                exp_q.push_back({err, w});
            end
            if (done && !room) m_ovr = 1'b1;
            else if (clear_overrun) m_ovr = 1'b0;
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on each handshake.
    always @(negedge clock) begin : monitor
        logic [WIDTH:0] e;
        if (mon_en) begin
            chk("out_valid", out_valid, m_full);
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, frame_q.size() != 0);
            if (out_valid && out_ready && reset_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: handshake with empty scoreboard, got %0h", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", out_data, e[WIDTH-1:0]);
`ifdef DESER_PARITY_EN
                    chk("parity_err", parity_err, e[WIDTH]);
`endif
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Bit pulses without frame_start are ignored from IDLE.
        repeat (3) drive_bit(1'b1, 1'b0);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data", out_data, 0);

        // Single frame with consumer ready: one-cycle valid pulse.
        out_ready = 1'b1;
        drive_bit(1'b1, 1'b1);
        chk("first_bit_busy", busy, 1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
`ifdef DESER_PARITY_EN
        drive_bit(1'b1, 1'b0);
`endif
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 4'b1011);
        chk("single_busy", busy, 0);
        tick();
        chk("single_pulse", out_valid, 0);

        // Gapped bits yield the same word.
        send_frame(4'b1011, 3, 1'b0);
        chk("gap_valid", out_valid, 1);
        chk("gap_data", out_data, 4'b1011);
        tick();

        // Overrun: second word dropped while first is held.
        out_ready = 1'b0;
        send_frame(4'b0110, 0, 1'b0);
        send_frame(4'b1001, 0, 1'b0);
        chk("ovr_data", out_data, 4'b0110);
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", out_valid, 1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("ovr_cleared", overrun, 0);
        out_ready = 1'b1;
        tick();
        chk("ovr_consumed", out_valid, 0);

        // Restart mid-frame: partial 1,1 is abandoned.
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        send_frame(4'b0010, 0, 1'b0);
        chk("restart_data", out_data, 4'b0010);
        chk("restart_valid", out_valid, 1);
        chk("restart_ovr", overrun, 0);
        tick();

`ifdef DESER_PARITY_EN
        send_frame(4'b1011, 0, 1'b0);
        chk("par_ok_err", parity_err, 0);
        tick();
        send_frame(4'b1011, 0, 1'b1);
        chk("par_bad_err", parity_err, 1);
        chk("par_bad_valid", out_valid, 1);
        chk("par_bad_data", out_data, 4'b1011);
        tick();
`endif

        // Random traffic, including occasional mid-frame resets.
        repeat (3000) begin
            reset_n       = ($urandom_range(0, 299) != 0);
            bit_en        = ($urandom_range(0, 9) < 7);
            serial_in     = 1'($urandom);
            frame_start   = bit_en && ($urandom_range(0, 9) == 0);
            out_ready     = ($urandom_range(0, 9) < 4);
            clear_overrun = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset_n       = 1'b1;
        bit_en        = 1'b0;
        frame_start   = 1'b0;
        clear_overrun = 1'b0;
        out_ready     = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
